button_led_scheduler: RTL

BUTTON_LED_SCHEDULER -- requirements
Module: button_led_scheduler

---
 rtl/button_led_if.sv | 11 +
 rtl/button_led_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/button_led_if.sv
// Button/LED bundle between the push-button front panel and the blink scheduler.
interface button_led_if;
  logic [3:0] btn;
  logic       led;
  logic [1:0] owner;
  logic       owner_valid;
  logic       done;

  modport master (output btn, input led, owner, owner_valid, done);
  modport slave  (input btn, output led, owner, owner_valid, done);
endinterface

// File: rtl/button_led_scheduler.sv
// Four debounced buttons queue press-release events; a round-robin FSM serves each
// by blinking the shared LED (button k gives k+1 blinks).
module button_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rel
);
  logic       s1, s2, db, db_q;
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) cnt <= '0;
      else if (cnt == 8'(DB_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else cnt <= cnt + 8'd1;
    end
  end

  // Event is the debounced release, seen one edge after db falls.
  assign rel = db_q & ~db;
endmodule

module button_led_scheduler #(
  parameter int DB_CYCLES  = 4,
  parameter int BLINK_HALF = 8
) (
  input logic        clk,
  input logic        rst,
  button_led_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t     state;
  logic [3:0] rel, pending, clr;
  logic [1:0] rr, pick, owner, blink;
  logic [7:0] phase;
  logic       hit, grant, led, owner_valid, done;

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk), .rst(rst), .btn(bus.btn[i]), .rel(rel[i])
    );
  end

  // Round-robin pick: descending scan so the nearest index after rr wins.
  always_comb begin
    logic [1:0] idx;
    hit  = 1'b0;
    pick = rr;
    idx  = rr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr + 2'(k);
      if (pending[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  // No grant during the done cycle keeps an idle, dark gap between sequences.
  assign grant = (state == IDLE) && !done && hit;
  assign clr   = grant ? (4'b0001 << pick) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | rel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      led         <= 1'b0;
      owner       <= '0;
      owner_valid <= 1'b0;
      done        <= 1'b0;
      rr          <= '0;
      phase       <= '0;
      blink       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          state       <= ON;
          owner       <= pick;
          rr          <= pick + 2'd1;
          led         <= 1'b1;
          owner_valid <= 1'b1;
          phase       <= '0;
          blink       <= '0;
        end
        ON: begin
          if (phase == 8'(BLINK_HALF - 1)) begin
            state <= OFF;
            led   <= 1'b0;
            phase <= '0;
          end else phase <= phase + 8'd1;
        end
        OFF: begin
          if (phase == 8'(BLINK_HALF - 1)) begin
            phase <= '0;
            if (blink == owner) begin
              state       <= IDLE;
              owner_valid <= 1'b0;
              done        <= 1'b1;
            end else begin
              state <= ON;
              led   <= 1'b1;
              blink <= blink + 2'd1;
            end
          end else phase <= phase + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led         = led;
  assign bus.owner       = owner;
  assign bus.owner_valid = owner_valid;
  assign bus.done        = done;
endmodule
